// File: rtl/my_pc_seq.sv
// 16-bit program-counter sequencer with a hardware return-address stack.
// Optional breakpoint logic is enabled by defining MY_PC_BRKPT_EN.

module my_inc16 (
    input  logic [15:0] in,
    output logic [15:0] out
);
    assign out = in + 16'd1;
endmodule

module my_pc_seq #(
    parameter int unsigned DEPTH     = 8,
    parameter logic [15:0] RESET_VEC = 16'h0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [15:0]                in,
    input  logic                       load,
    input  logic                       call,
    input  logic                       ret,
    input  logic                       inc,
`ifdef MY_PC_BRKPT_EN
    input  logic [15:0]                brk_addr,
    input  logic                       brk_en,
    input  logic                       resume,
    output logic                       brk_hit,
`endif
    output logic [15:0]                out,
    output logic [$clog2(DEPTH):0]     depth_cnt,
    output logic                       err_ovf,
    output logic                       err_unf
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [15:0]   pc_q, pc_d, pc_inc;
    logic [CW-1:0] depth_q, depth_d, depth_m1;
    logic          ovf_q, ovf_d, unf_q, unf_d;
    logic          push;
    logic          frozen;
    logic [15:0]   stack_q [DEPTH];

    my_inc16 u_inc (
        .in  (pc_q),
        .out (pc_inc)
    );

`ifdef MY_PC_BRKPT_EN
    assign brk_hit = brk_en & (pc_q == brk_addr) & ~resume;
    assign frozen  = brk_hit;
`else
    assign frozen  = 1'b0;
`endif

    assign depth_m1 = depth_q - CW'(1);

    always_comb begin
        pc_d    = pc_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        if (!frozen) begin
            if (load) begin
                pc_d = in;
            end else if (call) begin
                if (depth_q < FULL) begin
                    push    = 1'b1;
                    depth_d = depth_q + CW'(1);
                    pc_d    = in;
                end else begin
                    ovf_d = 1'b1;
                end
            end else if (ret) begin
                if (depth_q != '0) begin
                    depth_d = depth_m1;
                    pc_d    = stack_q[depth_m1[AW-1:0]];
                end else begin
                    unf_d = 1'b1;
                end
            end else if (inc) begin
                pc_d = pc_inc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q    <= RESET_VEC;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    // Stack storage needs no reset; entries are never read above depth_cnt.
    always_ff @(posedge clk) begin
        if (push && !reset) begin
            stack_q[depth_q[AW-1:0]] <= pc_inc;
        end
    end

    assign out       = pc_q;
    assign depth_cnt = depth_q;
    assign err_ovf   = ovf_q;
    assign err_unf   = unf_q;

endmodule
